// File: rtl/sync_mem_pkg.sv
// Shared types and helpers for the self-clearing synchronous memory.
package sync_mem_pkg;

  // Controller states: CLEAR sweeps zeros through the array, IDLE serves requests.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_t;

  // Even parity bit for a word of up to 64 bits. Callers zero-extend narrower
  // words; the extra zero bits do not change the parity.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/sync_mem_array.sv
// Word storage for sync_mem_clr: one synchronous write port and one
// registered read port sharing a single address. Storage is never reset;
// the controller clears it with a write sweep instead.
module sync_mem_array #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: commit at the edge so a read on the following cycle sees it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port: capture the addressed word; it stays valid for the whole next cycle.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sync_mem_clr.sv
// sync_mem_clr: single-port RAM with a hardware clear sweep after reset,
// registered read path with rvalid strobe, shared tristate data bus and an
// err pulse for read/write collisions.
//
// Optional build macro SYNC_MEM_CLR_PARITY_EN: each word carries an extra
// even-parity bit written alongside the data; a read whose stored parity
// does not match its data raises err in the same cycle as rvalid (the word
// is still driven onto the bus).
module sync_mem_clr
  import sync_mem_pkg::*;
#(
  parameter int WWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [AWIDTH-1:0] addr,
  inout  wire  [WWIDTH-1:0] data,
  output logic              busy,
  output logic              rvalid,
  output logic              err
);

`ifdef SYNC_MEM_CLR_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Stored word width: data plus the optional parity bit in the MSB.
  localparam int MW = WWIDTH + PAR_W;

  mem_state_t        state;
  logic [AWIDTH-1:0] cnt;
  logic              busy_p1;
  logic              vld_p1;
  logic              coll_p1;
  logic              par_err;

  logic              accept_rd;
  logic              accept_wr;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [MW-1:0]     wword;
  logic [MW-1:0]     rword_p1;

  // Request decode and array port steering. During the sweep the counter
  // owns the array and the bus request lines are ignored entirely.
  always_comb begin
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr;
    wword     = '0;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = cnt;
      wword    = '0;
    end else begin
      accept_rd = read && !write;
      accept_wr = write && !read;
      mem_we    = accept_wr;
      mem_addr  = addr;
`ifdef SYNC_MEM_CLR_PARITY_EN
      wword     = {even_parity(64'(data)), data};
`else
      wword     = data;
`endif
    end
  end

  // ---- stage p0 -> p1: array access, request outcome registered ----

  sync_mem_array #(
    .WIDTH  (MW),
    .AWIDTH (AWIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (accept_rd),
    .addr  (mem_addr),
    .wdata (wword),
    .rdata (rword_p1)
  );

  // Controller FSM: clear sweep after reset, then registered read/collision strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      busy_p1 <= 1'b1;
      vld_p1  <= 1'b0;
      coll_p1 <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      coll_p1 <= 1'b0;
      case (state)
        CLEAR: begin
          // The counter wraps to zero on the last address; no extra bit needed.
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state   <= IDLE;
            busy_p1 <= 1'b0;
          end
        end
        IDLE: begin
          vld_p1  <= accept_rd;
          coll_p1 <= read && write;
        end
      endcase
    end
  end

  // ---- stage p1: output presentation ----

  // Parity check on the registered read word; only meaningful while it is valid.
`ifdef SYNC_MEM_CLR_PARITY_EN
  assign par_err = vld_p1 &&
                   (even_parity(64'(rword_p1[WWIDTH-1:0])) != rword_p1[WWIDTH]);
`else
  assign par_err = 1'b0;
`endif

  assign busy   = busy_p1;
  assign rvalid = vld_p1;
  assign err    = coll_p1 || par_err;

  // The block only drives the shared bus while presenting a read word.
  assign data = vld_p1 ? rword_p1[WWIDTH-1:0] : {WWIDTH{1'bz}};

endmodule

// File: tb/tb_sync_mem_clr.sv
// Self-checking bench for sync_mem_clr (WWIDTH=8, AWIDTH=5): directed steps
// followed by random traffic checked against a word-array reference model.
module tb_sync_mem_clr;

  localparam int WW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

`ifdef SYNC_MEM_CLR_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [WW-1:0] drv;
  logic          drv_en;
  wire  [WW-1:0] data;
  logic          busy;
  logic          rvalid;
  logic          err;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] mdl [DEPTH];

  assign data = drv_en ? drv : {WW{1'bz}};

  sync_mem_clr #(.WWIDTH(WW), .AWIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .read   (read),
    .write  (write),
    .addr   (addr),
    .data   (data),
    .busy   (busy),
    .rvalid (rvalid),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  // One bus cycle in IDLE: present the request, predict from the model, check after the edge.
  task automatic do_cycle(input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [WW-1:0] d, input string tag);
    logic          e_v;
    logic          e_err;
    logic [WW-1:0] e_d;
    read   = r;
    write  = w;
    addr   = a;
    drv    = d;
    drv_en = w;
    e_v    = 1'b0;
    e_err  = 1'b0;
    e_d    = '0;
    if (r && w) e_err = 1'b1;
    else if (r) begin
      e_v = 1'b1;
      e_d = mdl[a];
    end else if (w) mdl[a] = d;
    @(posedge clk);
    #1;
    check({tag, "_rvalid"}, 64'(rvalid), 64'(e_v));
    check({tag, "_err"}, 64'(err), 64'(e_err));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    if (e_v) check({tag, "_data"}, 64'(data), 64'(e_d));
  endtask

  task automatic idle(input string tag);
    do_cycle(1'b0, 1'b0, '0, '0, tag);
  endtask

  // Count edges until busy falls while hammering the request lines, which must be ignored.
  task automatic count_sweep(input logic r, input logic w, output int n);
    read   = r;
    write  = w;
    addr   = 5'd7;
    drv    = 8'h5A;
    drv_en = w;
    n      = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      check("sweep_rvalid", 64'(rvalid), 64'd0);
      check("sweep_err", 64'(err), 64'd0);
      if (!busy) break;
    end
    read   = 1'b0;
    write  = 1'b0;
    drv_en = 1'b0;
  endtask

  initial begin
    int            n;
    logic          prev_rd;
    int            op;
    logic [AW-1:0] ra;
    logic [WW-1:0] rd;

    rst = 1'b1; read = 1'b0; write = 1'b0; addr = '0; drv = '0; drv_en = 1'b0;
    clear_model();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // 1: sweep length and cleared contents
    rst = 1'b0;
    count_sweep(1'b1, 1'b0, n);
    check("sweep_len_first", 64'(n), 64'd32);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, AW'(i), '0, "clr_rd");
    idle("clr_idle");

    // 2: write address pattern, back-to-back readback
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b1, AW'(i), WW'(i), "pat_wr");
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, AW'(i), '0, "pat_rd");
    idle("pat_idle");

    // 3: read immediately after write
    do_cycle(1'b0, 1'b1, 5'd3, 8'hA5, "wr3");
    do_cycle(1'b1, 1'b0, 5'd3, 8'h00, "rd3");
    idle("rd3_idle");

    // 4: collision leaves array unchanged and pulses err once
    do_cycle(1'b0, 1'b1, 5'd9, 8'h3C, "wr9");
    do_cycle(1'b1, 1'b1, 5'd9, 8'hFF, "coll9");
    idle("coll9_idle");
    do_cycle(1'b1, 1'b0, 5'd9, 8'h00, "rd9");
    idle("rd9_idle");

    // 5: async reset during a pending read, then again mid-sweep
    do_cycle(1'b0, 1'b1, 5'd7, 8'hFF, "wr7");
    do_cycle(1'b1, 1'b0, 5'd7, 8'h00, "rd7_pre");
    read = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_rst_rvalid", 64'(rvalid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd1);
    #1 rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("sweep10_busy", 64'(busy), 64'd1);
    end
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    count_sweep(1'b1, 1'b1, n);
    check("sweep_len_restart", 64'(n), 64'd32);
    clear_model();
    do_cycle(1'b1, 1'b0, 5'd7, 8'h00, "rd7_post");
    idle("rd7_idle");

    // 6: corrupted stored bit; err only with the parity build
    do_cycle(1'b0, 1'b1, 5'd4, 8'h01, "wr4");
    idle("wr4_idle");
    dut.u_array.mem[4][0] <= ~dut.u_array.mem[4][0];
    #1;
    mdl[4] = 8'h00;
    read = 1'b1; write = 1'b0; addr = 5'd4; drv_en = 1'b0;
    @(posedge clk);
    #1;
    check("par_rvalid", 64'(rvalid), 64'd1);
    check("par_data", 64'(data), 64'h00);
    check("par_err", 64'(err), 64'(PAR_ON));
    idle("par_idle");
    do_cycle(1'b0, 1'b1, 5'd4, 8'h01, "wr4_fix");

    // Random traffic against the model
    prev_rd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      ra = AW'($urandom_range(0, DEPTH - 1));
      rd = WW'($urandom);
      if (prev_rd && op >= 1 && op <= 4) op = 0;
      if (prev_rd && op == 9) op = 0;
      if (op >= 1 && op <= 4) begin
        do_cycle(1'b0, 1'b1, ra, rd, "rnd_wr");
        prev_rd = 1'b0;
      end else if (op >= 5 && op <= 8) begin
        do_cycle(1'b1, 1'b0, ra, '0, "rnd_rd");
        prev_rd = 1'b1;
      end else if (op == 9) begin
        do_cycle(1'b1, 1'b1, ra, rd, "rnd_coll");
        prev_rd = 1'b0;
      end else begin
        idle("rnd_idle");
        prev_rd = 1'b0;
      end
    end
    idle("rnd_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
